sram_port_arb: RTL and testbench

- Parametrised arbiter that merges CH_NUM core-side SRAM request channels onto one physical SRAM port; generalises the core's fixed instruction/data SRAM pair.
- Sits between the awmips core's SRAM request ports and the board SRAM controller.
- Produces a per-channel structural-stall signal that feeds the core's structural-stall input.
- Supports configurable wait states and selectable arbitration.

---
 rtl/sram_port_arb_if.sv | 33 +++
 rtl/sram_port_arb.sv | 153 +++++++++++++++
 tb/tb_sram_port_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arb_if.sv
// rtl/sram_port_arb_if.sv - Core-side channel and physical SRAM signal bundle for sram_port_arb
interface sram_port_arb_if #(
    parameter int CH_NUM = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [CH_NUM-1:0]          CH_CE;
    logic [CH_NUM-1:0]          CH_WE;
    logic [CH_NUM*DATA_W/8-1:0] CH_BE;
    logic [CH_NUM*ADDR_W-1:0]   CH_ADDR;
    logic [CH_NUM*DATA_W-1:0]   CH_WDATA;
    logic [DATA_W-1:0]          CH_RDATA;
    logic [CH_NUM-1:0]          CH_ACK;
    logic [CH_NUM-1:0]          CH_STALL;
    logic                       SRAM_CE;
    logic                       SRAM_WE;
    logic [DATA_W/8-1:0]        SRAM_BE;
    logic [ADDR_W-1:0]          SRAM_ADDR;
    logic [DATA_W-1:0]          SRAM_WDATA;
    logic [DATA_W-1:0]          SRAM_RDATA;

    modport slave (
        input  CH_CE, CH_WE, CH_BE, CH_ADDR, CH_WDATA, SRAM_RDATA,
        output CH_RDATA, CH_ACK, CH_STALL,
        output SRAM_CE, SRAM_WE, SRAM_BE, SRAM_ADDR, SRAM_WDATA
    );

    modport master (
        output CH_CE, CH_WE, CH_BE, CH_ADDR, CH_WDATA, SRAM_RDATA,
        input  CH_RDATA, CH_ACK, CH_STALL,
        input  SRAM_CE, SRAM_WE, SRAM_BE, SRAM_ADDR, SRAM_WDATA
    );
endinterface

// File: rtl/sram_port_arb.sv
// rtl/sram_port_arb.sv - Merges CH_NUM SRAM request channels onto one SRAM port with wait states.
// Define RR_ARB_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module sram_port_arb #(
    parameter int CH_NUM      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           CLK,
    input  logic           RST,
    sram_port_arb_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [CH_NUM-1:0]   grant_q, grant_d;
    logic [CH_NUM-1:0]   ack_q, ack_d;
    logic                sram_ce_q, sram_ce_d;
    logic                sram_we_q, sram_we_d;
    logic [BE_W-1:0]     sram_be_q, sram_be_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                req_any;
    logic [IDX_W-1:0]    win_idx;

    assign req_any = |bus.CH_CE;

`ifdef RR_ARB_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Walk offsets from the far end so the channel closest to the pointer is assigned last.
    always_comb begin
        int j;
        j       = 0;
        win_idx = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= CH_NUM) j = j - CH_NUM;
            if (bus.CH_CE[j]) win_idx = IDX_W'(j);
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (bus.CH_CE[i]) win_idx = IDX_W'(i);
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        ack_d        = '0;
        sram_ce_d    = sram_ce_q;
        sram_we_d    = sram_we_q;
        sram_be_d    = sram_be_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        rdata_d      = rdata_q;
`ifdef RR_ARB_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    sram_ce_d        = 1'b1;
                    sram_we_d        = bus.CH_WE[win_idx];
                    sram_be_d        = bus.CH_BE[win_idx*BE_W +: BE_W];
                    sram_addr_d      = bus.CH_ADDR[win_idx*ADDR_W +: ADDR_W];
                    sram_wdata_d     = bus.CH_WDATA[win_idx*DATA_W +: DATA_W];
                    cnt_d            = 4'(WAIT_CYCLES);
                    state_d          = ACCESS;
`ifdef RR_ARB_EN
                    rr_ptr_d = (win_idx == IDX_W'(CH_NUM - 1)) ? '0 : win_idx + 1'b1;
`endif
                end else begin
                    sram_ce_d = 1'b0;
                    sram_we_d = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Read data is only taken on the final access cycle, when the SRAM has settled.
                    if (!sram_we_q) rdata_d = bus.SRAM_RDATA;
                    sram_ce_d = 1'b0;
                    sram_we_d = 1'b0;
                    ack_d     = grant_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_be_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            sram_ce_q    <= sram_ce_d;
            sram_we_q    <= sram_we_d;
            sram_be_q    <= sram_be_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

`ifdef RR_ARB_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign bus.CH_ACK     = ack_q;
    assign bus.CH_STALL   = bus.CH_CE & ~ack_q;
    assign bus.CH_RDATA   = rdata_q;
    assign bus.SRAM_CE    = sram_ce_q;
    assign bus.SRAM_WE    = sram_we_q;
    assign bus.SRAM_BE    = sram_be_q;
    assign bus.SRAM_ADDR  = sram_addr_q;
    assign bus.SRAM_WDATA = sram_wdata_q;
endmodule

// File: tb/tb_sram_port_arb.sv
// tb/tb_sram_port_arb.sv - Randomized bench for sram_port_arb against a transaction-timeline model.
module tb_sram_port_arb;
    localparam int CH = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W1 = 1;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    sram_port_arb_if #(.CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
    sram_port_arb_if #(.CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW)) bus0 ();

    sram_port_arb #(.CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W1)) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1));
    sram_port_arb #(.CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RST(RST), .bus(bus0));

    logic [1:0]  r_ce, r_we, rearm;
    logic [3:0]  r_be    [CH];
    logic [31:0] r_addr  [CH];
    logic [31:0] r_wdata [CH];

    assign bus1.CH_CE    = r_ce;
    assign bus1.CH_WE    = r_we;
    assign bus1.CH_BE    = {r_be[1], r_be[0]};
    assign bus1.CH_ADDR  = {r_addr[1], r_addr[0]};
    assign bus1.CH_WDATA = {r_wdata[1], r_wdata[0]};

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i * 37);
    endfunction

    // Physical SRAM stand-in: 64 words, reloaded while reset is held.
    logic [31:0] mem [64];
    always @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (bus1.SRAM_CE && bus1.SRAM_WE) begin
            for (int b = 0; b < 4; b++)
                if (bus1.SRAM_BE[b]) mem[bus1.SRAM_ADDR[7:2]][8*b +: 8] <= bus1.SRAM_WDATA[8*b +: 8];
        end
    end
    assign bus1.SRAM_RDATA = mem[bus1.SRAM_ADDR[7:2]];
    assign bus0.SRAM_RDATA = bus0.SRAM_ADDR ^ 32'h5A5A_0000;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] ref_mem [64];
    bit          m_busy;
    int          m_start, m_ch, rr_ptr;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rd, exp_rdata;
    logic [1:0]  exp_ack;
    int          ack_cyc [CH];
    int          ce_seen, ack_seen;
    int          order [$];

    task automatic model_reset();
        m_busy    = 1'b0;
        exp_rdata = '0;
        exp_ack   = '0;
        rr_ptr    = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    endtask

    function automatic int pick(input logic [1:0] ce);
        int j;
`ifdef RR_ARB_EN
        for (int k = 0; k < CH; k++) begin
            j = (rr_ptr + k) % CH;
            if (ce[j]) return j;
        end
`else
        for (j = 0; j < CH; j++) if (ce[j]) return j;
`endif
        return 0;
    endfunction

    // One clock of the timeline model: arbitration at start s, SRAM busy s+1..s+1+W, ack s+2+W, free at s+3+W.
    task automatic step();
        logic [1:0] exp_stall;
        logic       exp_ce;
        int         ch;
        @(negedge CLK);
        if (m_busy && cyc >= m_start + W1 + 3) m_busy = 1'b0;
        if (!m_busy && r_ce != 2'b00) begin
            ch      = pick(r_ce);
            m_busy  = 1'b1;
            m_start = cyc;
            m_ch    = ch;
            m_we    = r_we[ch];
            m_be    = r_be[ch];
            m_addr  = r_addr[ch];
            m_wdata = r_wdata[ch];
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) ref_mem[m_addr[7:2]][8*b +: 8] = m_wdata[8*b +: 8];
            end else begin
                m_rd = ref_mem[m_addr[7:2]];
            end
            rr_ptr = (ch + 1) % CH;
        end
        exp_ce    = m_busy && cyc >= m_start + 1 && cyc <= m_start + 1 + W1;
        exp_ack   = (m_busy && cyc == m_start + 2 + W1) ? 2'(1 << m_ch) : 2'b00;
        if (exp_ack != 2'b00 && !m_we) exp_rdata = m_rd;
        exp_stall = r_ce & ~exp_ack;

        if (bus1.SRAM_CE) ce_seen++;
        for (int c = 0; c < CH; c++)
            if (bus1.CH_ACK[c]) begin ack_cyc[c] = cyc; ack_seen++; order.push_back(c); end

        vectors++;
        if (bus1.CH_ACK !== exp_ack) begin
            miscompares++; $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, bus1.CH_ACK, exp_ack);
        end
        vectors++;
        if (bus1.CH_STALL !== exp_stall) begin
            miscompares++; $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, bus1.CH_STALL, exp_stall);
        end
        vectors++;
        if (bus1.SRAM_CE !== exp_ce) begin
            miscompares++; $display("FAIL sram_ce cyc=%0d got=%b exp=%b", cyc, bus1.SRAM_CE, exp_ce);
        end
        vectors++;
        if (bus1.SRAM_WE !== (exp_ce & m_we)) begin
            miscompares++; $display("FAIL sram_we cyc=%0d got=%b exp=%b", cyc, bus1.SRAM_WE, exp_ce & m_we);
        end
        vectors++;
        if (bus1.CH_RDATA !== exp_rdata) begin
            miscompares++; $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, bus1.CH_RDATA, exp_rdata);
        end
        if (exp_ce) begin
            vectors++;
            if (bus1.SRAM_ADDR !== m_addr || bus1.SRAM_BE !== m_be || (m_we && bus1.SRAM_WDATA !== m_wdata)) begin
                miscompares++;
                $display("FAIL sram_bus cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, bus1.SRAM_ADDR,
                         bus1.SRAM_BE, bus1.SRAM_WDATA, m_addr, m_be, m_wdata);
            end
        end
        @(posedge CLK);
        cyc++;
        #1;
        r_ce = (r_ce & ~exp_ack) | (exp_ack & rearm);
    endtask

    task automatic clear_obs();
        ce_seen = 0; ack_seen = 0; order.delete();
        for (int c = 0; c < CH; c++) ack_cyc[c] = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if (bus1.SRAM_CE !== 1'b0 || bus1.SRAM_WE !== 1'b0 || bus1.CH_ACK !== 2'b00) begin
            miscompares++; $display("FAIL reset_ctrl got=%b%b%b exp=0000", bus1.SRAM_CE, bus1.SRAM_WE, bus1.CH_ACK);
        end
        vectors++;
        if (bus1.CH_RDATA !== 32'h0 || bus1.SRAM_ADDR !== 32'h0 || bus1.SRAM_WDATA !== 32'h0) begin
            miscompares++; $display("FAIL reset_data got=%h/%h exp=0/0", bus1.CH_RDATA, bus1.SRAM_ADDR);
        end
        vectors++;
        if (bus0.SRAM_CE !== 1'b0 || bus0.CH_ACK !== 2'b00 || bus0.CH_RDATA !== 32'h0) begin
            miscompares++; $display("FAIL reset_dut0 got=%b/%b/%h exp=0", bus0.SRAM_CE, bus0.CH_ACK, bus0.CH_RDATA);
        end
        RST = 1'b1;
        cyc = 0;
    endtask

    task automatic test_read();
        int t;
        clear_obs();
        r_ce = 2'b10; r_we = 2'b00; r_addr[1] = 32'h40; r_be[1] = 4'hF;
        t = cyc;
        repeat (6) step();
        vectors++;
        if (ack_cyc[1] !== t + 3) begin
            miscompares++; $display("FAIL read_ack_cycle got=%0d exp=%0d", ack_cyc[1], t + 3);
        end
        vectors++;
        if (ce_seen !== W1 + 1) begin
            miscompares++; $display("FAIL read_ce_len got=%0d exp=%0d", ce_seen, W1 + 1);
        end
        vectors++;
        if (bus1.CH_RDATA !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL read_data got=%h exp=deadbeef", bus1.CH_RDATA);
        end
    endtask

    task automatic test_contention();
        int t;
        clear_obs();
        r_we = 2'b01; r_be[0] = 4'b0011; r_addr[0] = 32'h100; r_wdata[0] = 32'h1234_5678;
        r_be[1] = 4'hF; r_addr[1] = 32'h100;
        r_ce = 2'b11;
        t = cyc;
        repeat (10) step();
        vectors++;
        if (ack_cyc[0] !== t + 3 || ack_cyc[1] !== t + 7) begin
            miscompares++;
            $display("FAIL contend_acks got=%0d,%0d exp=%0d,%0d", ack_cyc[0], ack_cyc[1], t + 3, t + 7);
        end
        vectors++;
        if (bus1.CH_RDATA !== ((init_word(0) & 32'hFFFF_0000) | 32'h0000_5678)) begin
            miscompares++; $display("FAIL contend_readback got=%h", bus1.CH_RDATA);
        end
    endtask

    task automatic test_priority();
        int exp_order [4];
`ifdef RR_ARB_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        clear_obs();
        r_we = 2'b00; r_addr[0] = 32'h8; r_addr[1] = 32'hC;
        rearm = 2'b11; r_ce = 2'b11;
        for (int n = 0; n < 40 && order.size() < 4; n++) step();
        rearm = 2'b00; r_ce = 2'b00;
        repeat (W1 + 4) step();
        vectors++;
        if (order.size() < 4) begin
            miscompares++; $display("FAIL prio_count got=%0d exp=4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (order[i] !== exp_order[i]) begin
                    miscompares++; $display("FAIL prio_order idx=%0d got=%0d exp=%0d", i, order[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_drop();
        int t;
        clear_obs();
        r_we = 2'b00; r_addr[1] = 32'h44; r_ce = 2'b10;
        t = cyc;
        step(); step();
        r_ce[1] = 1'b0;
        repeat (6) step();
        vectors++;
        if (ack_cyc[1] !== t + 3 || ack_seen !== 1 || ce_seen !== W1 + 1) begin
            miscompares++;
            $display("FAIL drop got=%0d/%0d/%0d exp=%0d/1/%0d", ack_cyc[1], ack_seen, ce_seen, t + 3, W1 + 1);
        end
    endtask

    task automatic test_async_reset();
        int t;
        clear_obs();
        r_we = 2'b01; r_be[0] = 4'hF; r_addr[0] = 32'h20; r_wdata[0] = 32'hA5A5_5A5A; r_ce = 2'b01;
        step(); step();
        #2;
        RST = 1'b0;
        #1;
        vectors++;
        if (bus1.SRAM_CE !== 1'b0 || bus1.SRAM_WE !== 1'b0 || bus1.CH_ACK !== 2'b00 || bus1.CH_RDATA !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset got=%b/%b/%b/%h exp=0", bus1.SRAM_CE, bus1.SRAM_WE, bus1.CH_ACK, bus1.CH_RDATA);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cyc++;
        model_reset();
        clear_obs();
        t = cyc;
        repeat (6) step();
        vectors++;
        if (ack_cyc[0] !== t + 3 || ce_seen !== W1 + 1) begin
            miscompares++; $display("FAIL restart got=%0d/%0d exp=%0d/%0d", ack_cyc[0], ce_seen, t + 3, W1 + 1);
        end
    endtask

    task automatic test_random();
        clear_obs();
        rearm = 2'b00;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (!r_ce[c] && $urandom_range(0, 2) == 0) begin
                    r_ce[c]    = 1'b1;
                    r_we[c]    = 1'($urandom_range(0, 1));
                    r_be[c]    = 4'($urandom_range(1, 15));
                    r_addr[c]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                    r_wdata[c] = $urandom;
                end
            end
            if (m_busy && r_ce[m_ch] && cyc > m_start && $urandom_range(0, 3) == 0) begin
                r_addr[m_ch]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                r_wdata[m_ch] = $urandom;
                r_we[m_ch]    = ~r_we[m_ch];
            end
            step();
        end
        r_ce = 2'b00;
        repeat (W1 + 4) step();
    endtask

    task automatic test_wait0();
        logic [31:0] wd;
        logic        exp_ce [4];
        logic [1:0]  exp_ak [4];
        exp_ce = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_ak = '{2'b00, 2'b00, 2'b01, 2'b00};
        wd = $urandom;
        for (int pass = 0; pass < 2; pass++) begin
            bus0.CH_CE    = 2'b01;
            bus0.CH_WE    = (pass == 1) ? 2'b01 : 2'b00;
            bus0.CH_BE    = 8'hFF;
            bus0.CH_ADDR  = {32'h0, (pass == 1) ? 32'h84 : 32'h80};
            bus0.CH_WDATA = {32'h0, wd};
            for (int k = 0; k < 4; k++) begin
                @(negedge CLK);
                vectors++;
                if (bus0.SRAM_CE !== exp_ce[k] || bus0.CH_ACK !== exp_ak[k]) begin
                    miscompares++;
                    $display("FAIL w0_timing pass=%0d k=%0d got=%b/%b exp=%b/%b", pass, k,
                             bus0.SRAM_CE, bus0.CH_ACK, exp_ce[k], exp_ak[k]);
                end
                vectors++;
                if (bus0.SRAM_WE !== (exp_ce[k] & (pass == 1))) begin
                    miscompares++; $display("FAIL w0_we pass=%0d k=%0d got=%b", pass, k, bus0.SRAM_WE);
                end
                if (k >= 2 || pass == 1) begin
                    vectors++;
                    if (bus0.CH_RDATA !== 32'h5A5A_0080) begin
                        miscompares++; $display("FAIL w0_rdata pass=%0d k=%0d got=%h exp=5a5a0080", pass, k, bus0.CH_RDATA);
                    end
                end
                if (k == 1 && pass == 1) begin
                    vectors++;
                    if (bus0.SRAM_WDATA !== wd || bus0.SRAM_ADDR !== 32'h84) begin
                        miscompares++; $display("FAIL w0_wbus got=%h/%h exp=%h/84", bus0.SRAM_WDATA, bus0.SRAM_ADDR, wd);
                    end
                end
                @(posedge CLK);
                #1;
                if (k == 2) bus0.CH_CE = 2'b00;
            end
        end
    endtask

    initial begin
        r_ce = '0; r_we = '0; rearm = '0;
        for (int c = 0; c < CH; c++) begin r_be[c] = '0; r_addr[c] = '0; r_wdata[c] = '0; end
        bus0.CH_CE = '0; bus0.CH_WE = '0; bus0.CH_BE = '0; bus0.CH_ADDR = '0; bus0.CH_WDATA = '0;
        model_reset();
        clear_obs();
        test_reset();
        test_read();
        test_contention();
        test_priority();
        test_drop();
        test_async_reset();
        test_random();
        test_wait0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
